// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RISC-V width codes, the
// arbiter FSM state type and the access legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_0400;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    // An access is rejected when out of range, of undefined width, or misaligned.
    function automatic logic access_err(input logic [2:0]  funct3,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic err;
        err = (addr >= limit);
        case (funct3)
            F3_B, F3_BU: ;
            F3_H, F3_HU: if (addr[0]) err = 1'b1;
            F3_W:        if (addr[1:0] != 2'b00) err = 1'b1;
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the last-grant pointer is kept
// by the parent so it only moves when a request is actually accepted.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for the data memory: one transaction
// at a time through IDLE -> ACCESS -> RESP, with illegal accesses rejected.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT,
    parameter int          NREQ       = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ-1:0][31:0]      req_addr,
    input  logic [NREQ-1:0][31:0]      req_wdata,
    input  logic [NREQ-1:0][2:0]       req_funct3,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_we,
    output logic [31:0]                mem_a,
    output logic [31:0]                mem_wd,
    output logic [2:0]                 mem_funct3,
    input  logic [31:0]                mem_rd
);

    arb_state_t      state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wd_q, wd_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [1:0]      grant;
    logic            sel;

    rr_arb2 u_arb (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign sel = grant[1];

    // Ready is withheld while reset is asserted even though the FSM already sits in IDLE.
    assign req_ready  = (state_q == IDLE && reset_n) ? grant : '0;
    assign mem_we     = (state_q == ACCESS) && we_q && !err_q;
    assign mem_a      = addr_q;
    assign mem_wd     = wd_q;
    assign mem_funct3 = f3_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        f3_d        = f3_q;
        rdata_d     = rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = '0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = sel;
                    last_d  = sel;
                    we_d    = req_we[sel];
                    addr_d  = req_addr[sel];
                    wd_d    = req_wdata[sel];
                    f3_d    = req_funct3[sel];
                    err_d   = access_err(req_funct3[sel], req_addr[sel], ADDR_LIMIT);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d              = (we_q || err_q) ? 32'h0 : mem_rd;
                rsp_err_d            = err_q;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= 32'h0;
            wd_q        <= 32'h0;
            f3_q        <= F3_W;
            rdata_q     <= 32'h0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            f3_q        <= f3_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][2:0]   req_funct3;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [31:0]       mem_a;
    logic [31:0]       mem_wd;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_rd;

    int vecCount  = 0;
    int missCount = 0;

    logic [7:0] ram    [0:1023];
    logic [7:0] refMem [0:1023];
    logic [9:0] ra;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_funct3 (mem_funct3),
        .mem_rd     (mem_rd)
    );

    // Width/sign extraction of a little-endian load, as the data memory performs it.
    function automatic logic [31:0] loadBytes(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3,
                                              input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign ra     = mem_a[9:0];
    assign mem_rd = loadBytes(ram[ra], ram[ra + 10'd1], ram[ra + 10'd2], ram[ra + 10'd3], mem_funct3);

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_funct3[1:0])
                2'b00: ram[ra] <= mem_wd[7:0];
                2'b01: begin
                    ram[ra]         <= mem_wd[7:0];
                    ram[ra + 10'd1] <= mem_wd[15:8];
                end
                default: begin
                    ram[ra]         <= mem_wd[7:0];
                    ram[ra + 10'd1] <= mem_wd[15:8];
                    ram[ra + 10'd2] <= mem_wd[23:16];
                    ram[ra + 10'd3] <= mem_wd[31:24];
                end
            endcase
        end
    end

    // Legality rules of an access, stated directly as arithmetic on the address.
    function automatic logic modelErr(input logic [31:0] addr, input logic [2:0] f3);
        if (addr >= 32'd1024) return 1'b1;
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return (addr % 2) != 0;
            3'b010:         return (addr % 4) != 0;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic int sizeOf(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int r, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3);
        req_we[r]     = we;
        req_addr[r]   = addr;
        req_wdata[r]  = wd;
        req_funct3[r] = f3;
    endtask

    // One complete transaction from a single requester; called just after a rising edge.
    task automatic applyStimulus(input int r, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [2:0] f3,
                                 input logic expErr, input logic [31:0] expRdata);
        logic got;
        got = 1'b0;
        setReq(r, we, addr, wd, f3);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = req_ready[r];
        end
        if (!got) begin
            checkOutput("ready_timeout", 32'(got), 32'd1);
            req_valid[r] = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        checkOutput("ready_onehot", 32'(req_ready), 32'(2'b01 << r));
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        checkOutput("access_mem_we", 32'(mem_we), 32'(we & ~expErr));
        if (we && !expErr) begin
            checkOutput("access_mem_a", mem_a, addr);
            checkOutput("access_mem_f3", 32'(mem_funct3), 32'(f3));
            checkOutput("access_mem_wd", mem_wd, wd);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("resp_mem_we", 32'(mem_we), 32'd0);
        checkOutput("resp_valid", 32'(rsp_valid), 32'(2'b01 << r));
        checkOutput("resp_err", 32'(rsp_err), 32'(expErr));
        checkOutput("resp_rdata", rsp_rdata, expRdata);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[16];

    // Random-phase state
    logic [1:0]  mLast;
    int          mPhase;
    int          mOwner;
    logic        mWe;
    logic        mErr;
    logic [31:0] mAddr;
    logic [31:0] mRdata;

    initial begin
        int          winner;
        int          diffs;
        logic [1:0]  expReady;
        logic [7:0]  saved [0:3];
        logic        got;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[16] = 8'hEF; ram[17] = 8'hBE; ram[18] = 8'hAD; ram[19] = 8'hDE;

        vecs[0]  = '{0, 1'b0, 32'h010, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1, 1'b1, 32'h021, 32'h0000_00AB, 3'b000, 1'b0, 32'h0};
        vecs[2]  = '{1, 1'b0, 32'h021, 32'h0,        3'b100, 1'b0, 32'h0000_00AB};
        vecs[3]  = '{0, 1'b0, 32'h021, 32'h0,        3'b000, 1'b0, 32'hFFFF_FFAB};
        vecs[4]  = '{0, 1'b1, 32'h402, 32'h1111_1111, 3'b010, 1'b1, 32'h0};
        vecs[5]  = '{0, 1'b0, 32'h003, 32'h0,        3'b001, 1'b1, 32'h0};
        vecs[6]  = '{1, 1'b0, 32'h000, 32'h0,        3'b011, 1'b1, 32'h0};
        vecs[7]  = '{1, 1'b1, 32'h400, 32'h2222_2222, 3'b010, 1'b1, 32'h0};
        vecs[8]  = '{0, 1'b0, 32'h000, 32'h0,        3'b010, 1'b0, 32'h0};
        vecs[9]  = '{0, 1'b0, 32'h012, 32'h0,        3'b101, 1'b0, 32'h0000_DEAD};
        vecs[10] = '{1, 1'b0, 32'h012, 32'h0,        3'b001, 1'b0, 32'hFFFF_DEAD};
        vecs[11] = '{0, 1'b1, 32'h030, 32'hFFFF_8001, 3'b001, 1'b0, 32'h0};
        vecs[12] = '{1, 1'b0, 32'h030, 32'h0,        3'b010, 1'b0, 32'h0000_8001};
        vecs[13] = '{0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 3'b010, 1'b0, 32'h0};
        vecs[14] = '{1, 1'b0, 32'h3FC, 32'h0,        3'b010, 1'b0, 32'hCAFE_F00D};
        vecs[15] = '{0, 1'b1, 32'h006, 32'h3333_3333, 3'b110, 1'b1, 32'h0};

        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_funct3 = '0;

        // Reset values while reset is held with both requesters asking.
        #12;
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_a", mem_a, 32'd0);
        checkOutput("rst_mem_wd", mem_wd, 32'd0);
        checkOutput("rst_mem_f3", 32'(mem_funct3), 32'(3'b010));
        req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].f3, vecs[i].err, vecs[i].rdata);
        end

        $display("[TB] contention");
        resetDut();
        setReq(0, 1'b0, 32'h010, 32'h0, 3'b010);
        setReq(1, 1'b0, 32'h030, 32'h0, 3'b010);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                got = |req_ready;
            end
            checkOutput("cont_ready", 32'(req_ready), 32'(2'b01 << (k % 2)));
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("cont_busy_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("cont_rsp_valid", 32'(rsp_valid), 32'(2'b01 << (k % 2)));
            checkOutput("cont_rdata", rsp_rdata, (k % 2 == 0) ? 32'hDEADBEEF : 32'h0000_8001);
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;

        $display("[TB] reset during access");
        resetDut();
        for (int i = 0; i < 4; i++) saved[i] = ram[8 + i];
        setReq(0, 1'b1, 32'h008, 32'h0000_1234, 3'b010);
        req_valid = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = req_ready[0];
        end
        checkOutput("mid_rst_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("mid_rst_we_before", 32'(mem_we), 32'd1);
        #1;
        reset_n = 1'b0;
        setReq(0, 1'b0, 32'h010, 32'h0, 3'b010);
        setReq(1, 1'b0, 32'h030, 32'h0, 3'b010);
        req_valid = 2'b11;
        #1;
        checkOutput("mid_rst_we_after", 32'(mem_we), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        diffs = 0;
        for (int i = 0; i < 4; i++) if (ram[8 + i] !== saved[i]) diffs++;
        checkOutput("mid_rst_ram", 32'(diffs), 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] cancelled request");
        setReq(0, 1'b0, 32'h010, 32'h0, 3'b010);
        setReq(1, 1'b0, 32'h030, 32'h0, 3'b010);
        req_valid = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = req_ready[0];
        end
        checkOutput("cancel_first_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        @(negedge clk);
        checkOutput("cancel_busy_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("cancel_no_ready1", 32'(req_ready[1]), 32'd0);
            checkOutput("cancel_no_rsp1", 32'(rsp_valid[1]), 32'd0);
        end
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        resetDut();
        for (int i = 0; i < 1024; i++) refMem[i] = ram[i];
        mLast  = 2'd1;
        mPhase = 0;
        mOwner = 0;
        mWe = 1'b0; mErr = 1'b0; mAddr = 32'h0; mRdata = 32'h0;
        for (int c = 0; c < 800; c++) begin
            int next;
            @(negedge clk);
            expReady = 2'b00;
            winner   = -1;
            next     = mPhase;
            case (mPhase)
                0: begin
                    if (req_valid == 2'b11)   winner = 1 - int'(mLast);
                    else if (req_valid[0])    winner = 0;
                    else if (req_valid[1])    winner = 1;
                    if (winner >= 0) expReady = 2'(1 << winner);
                    checkOutput("rnd_ready", 32'(req_ready), 32'(expReady));
                    checkOutput("rnd_idle_rsp", 32'(rsp_valid), 32'd0);
                    checkOutput("rnd_idle_we", 32'(mem_we), 32'd0);
                    if (winner >= 0) begin
                        mOwner = winner;
                        mLast  = 2'(winner);
                        mWe    = req_we[winner];
                        mAddr  = req_addr[winner];
                        mErr   = modelErr(req_addr[winner], req_funct3[winner]);
                        mRdata = 32'h0;
                        if (!mWe && !mErr) begin
                            mRdata = loadBytes(refMem[mAddr], refMem[mAddr + 1], refMem[mAddr + 2],
                                               refMem[mAddr + 3], req_funct3[winner]);
                        end
                        if (mWe && !mErr) begin
                            for (int b = 0; b < sizeOf(req_funct3[winner]); b++)
                                refMem[mAddr + b] = req_wdata[winner][8*b +: 8];
                        end
                        next = 1;
                    end
                end
                1: begin
                    checkOutput("rnd_access_ready", 32'(req_ready), 32'd0);
                    checkOutput("rnd_mem_we", 32'(mem_we), 32'(mWe & ~mErr));
                    if (mWe && !mErr) checkOutput("rnd_mem_a", mem_a, mAddr);
                    next = 2;
                end
                default: begin
                    checkOutput("rnd_resp_ready", 32'(req_ready), 32'd0);
                    checkOutput("rnd_rsp_valid", 32'(rsp_valid), 32'(1 << mOwner));
                    checkOutput("rnd_rsp_err", 32'(rsp_err), 32'(mErr));
                    checkOutput("rnd_rsp_rdata", rsp_rdata, mRdata);
                    next = 0;
                end
            endcase
            @(posedge clk);
            #1;
            mPhase = next;
            if (winner >= 0) req_valid[winner] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    logic [31:0] a;
                    if ($urandom_range(0, 9) == 0) a = 32'h3F8 + 32'($urandom_range(0, 15));
                    else                           a = 32'($urandom_range(0, 255));
                    setReq(r, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
                    req_valid[r] = 1'b1;
                end
            end
        end
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== refMem[i]) diffs++;
        checkOutput("rnd_ram_contents", 32'(diffs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressable data memory (we/a/wd/funct3 in, combinational rd out).
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
- Grants one transaction at a time, round-robin, and drives the memory port from registered request fields.
- Returns registered read data plus an error flag; rejects misaligned, out-of-range and undefined-funct3 accesses before they reach memory.

Parameters:
- ADDR_LIMIT, 32'h0000_0400, first invalid byte address (1 KB RAM).
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  [NREQ]  request pending, held until accepted
- req_ready  out  [NREQ]  accept strobe; transfer occurs when valid & ready
- req_we  in  [NREQ]  1 = store, 0 = load
- req_addr  in  [NREQ][32]  byte address
- req_wdata  in  [NREQ][32]  store data, right-aligned for SB/SH
- req_funct3  in  [NREQ][3]  RISC-V width/sign code
- rsp_valid  out  [NREQ]  one-cycle response pulse to the owning requester
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid
- mem_we  out  1  memory write enable
- mem_a  out  32  memory byte address
- mem_wd  out  32  memory write data
- mem_funct3  out  3  memory width code
- mem_rd  in  32  memory combinational read data

Behaviour:
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles; there is no pipelining.
- IDLE:
  - req_ready is combinational: asserted only to the arbitration winner, and only when its req_valid=1. At most one ready bit is high.
  - On the accepting edge: capture we/addr/wdata/funct3/owner, compute err, go to ACCESS.
- Arbitration: a last-grant pointer is cleared to 1 at reset, so requester 0 wins the first tie. When both are valid, the requester not last granted wins. A single valid requester always wins. The pointer updates only on acceptance.
- Error conditions (err=1):
  - addr >= ADDR_LIMIT
  - funct3 in {011, 110, 111}
  - funct3 in {001, 101} with addr[0]=1
  - funct3 = 010 with addr[1:0] != 0
- ACCESS:
  - mem_a/mem_wd/mem_funct3 driven from the captured registers.
  - mem_we = we & ~err, asserted for exactly this one cycle.
  - At the edge: rsp_rdata <= (we|err) ? 0 : mem_rd; rsp_err <= err.
- RESP:
  - rsp_valid[owner]=1 for one cycle. There is no back-pressure; the requester must take the response.
  - Return to IDLE. No request is accepted in RESP.
- Outside ACCESS: mem_we=0 and mem_a/mem_wd/mem_funct3 hold their last values (no glitching writes).
- Requester contract: fields must be stable while req_valid=1 and ready=0. Dropping valid before acceptance is allowed and cancels the request.
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE, pointer=1, all rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a/mem_wd=0, mem_funct3=3'b010, all req_ready=0 while reset_n=0.
  - Reset mid-ACCESS aborts the transaction; the write is suppressed if reset_n=0 at the edge. No response is ever issued for an aborted transaction.

Decomposition:
- Package dmem_pkg: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101), arb_state_t enum {IDLE, ACCESS, RESP}, and the access-check function (funct3, addr, limit) -> err.
- Sub-module rr_arb2: the combinational 2-way round-robin grant, taking valid and last-grant pointer. Pointer register lives in the parent.

Test Plan:
- Single load: req0 LW addr 0x10 (mem word 0xDEADBEEF) -> ready0 in cycle 0, mem_we=0 in cycle 1, rsp_valid[0] in cycle 2 with rdata=0xDEADBEEF, err=0.
- Store then load: req1 SB addr 0x21 data 0xAB, then LBU 0x21 -> mem_we pulses once with mem_a=0x21, funct3=000; load returns 0x000000AB.
- Contention: both valid continuously, 4 transactions -> grant order 0,1,0,1; never two ready bits high; each response goes only to its owner.
- Errors, each gives rsp_err=1, rdata=0, mem_we never asserted:
  - SW to 0x402
  - LH at 0x03
  - funct3=011 at 0x0
  - SW to 0x400
- Reset mid-ACCESS with req0 SW 0x8 data 0x1234: assert reset_n=0 before the edge -> mem[0x8] unchanged, no rsp_valid, first post-reset grant goes to requester 0.
- Cancel: req1 valid for 1 cycle while a transaction is busy, then deasserted -> never granted, no response.
